// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared encodings for the instruction fetch stage.
// Holds the next_PC_select codes, the fetch FSM state codes and the PC step.
package fetch_unit_pkg;

    // next_PC_select encodings fed back from IF/ID
    localparam logic [1:0] PCSEL_SEQ    = 2'b00;
    localparam logic [1:0] PCSEL_BRANCH = 2'b01;
    localparam logic [1:0] PCSEL_JAL    = 2'b10;
    localparam logic [1:0] PCSEL_JALR   = 2'b11;

    // Fetch FSM states (legacy-compatible constant encoding)
    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t ST_REQ  = 2'd0;
    localparam fetch_state_t ST_WAIT = 2'd1;
    localparam fetch_state_t ST_HOLD = 2'd2;

    // Sequential PC step in bytes
    localparam int unsigned PC_INCREMENT = 4;

endpackage

// File: rtl/fetch_unit_next_pc.sv
// fetch_next_pc: combinational redirect detection and target selection.
// Targets are forced to word alignment.
module fetch_next_pc
    import fetch_unit_pkg::*;
#(
    parameter int ADDRESS_BITS = 20
) (
    input  logic                    branch,
    input  logic [1:0]              next_PC_select,
    input  logic [ADDRESS_BITS-1:0] branch_target,
    input  logic [ADDRESS_BITS-1:0] JAL_target,
    input  logic [ADDRESS_BITS-1:0] JALR_target,
    output logic                    redirect,
    output logic [ADDRESS_BITS-1:0] target
);

    // Decode the select code into a redirect flag and an aligned target
    always_comb begin
        redirect = 1'b0;
        target   = branch_target;
        case (next_PC_select)
            PCSEL_SEQ:    redirect = 1'b0;
            PCSEL_BRANCH: redirect = branch;
            PCSEL_JAL: begin
                redirect = 1'b1;
                target   = JAL_target;
            end
            PCSEL_JALR: begin
                redirect = 1'b1;
                target   = JALR_target;
            end
            default:      redirect = 1'b0;
        endcase
        target[1:0] = 2'b00;
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, issues one read at a
// time to instruction memory and presents instruction/PC pairs to IF/ID.
// Optional perf counters are built when FETCH_PERF_COUNTERS_EN is defined.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                      CORE         = 0,
    parameter int                      DATA_WIDTH   = 32,
    parameter int                      ADDRESS_BITS = 20,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    branch,
    input  logic [ADDRESS_BITS-1:0] branch_target,
    input  logic [ADDRESS_BITS-1:0] JAL_target,
    input  logic [ADDRESS_BITS-1:0] JALR_target,
    input  logic [1:0]              next_PC_select,
    input  logic                    stall,
    output logic                    imem_req_valid,
    output logic [ADDRESS_BITS-1:0] imem_req_addr,
    input  logic                    imem_req_ready,
    input  logic                    imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   imem_rsp_data,
    output logic [DATA_WIDTH-1:0]   instruction,
    output logic [ADDRESS_BITS-1:0] inst_PC,
    output logic                    inst_valid,
    output logic [31:0]             fetch_count,
    output logic [31:0]             squash_count
);

    if (ADDRESS_BITS < 3 || CORE < 0 || RESET_PC[1:0] != 2'b00) begin : g_bad_cfg
        $error("fetch_unit: invalid parameter configuration");
    end

    logic [ADDRESS_BITS-1:0] pc;
    fetch_state_t            state;
    logic                    started;
    logic                    drop;
    logic                    skid_valid;
    logic [DATA_WIDTH-1:0]   skid_data;
    logic [ADDRESS_BITS-1:0] skid_pc;
    logic                    redirect;
    logic [ADDRESS_BITS-1:0] redirect_target;
    logic                    accept;
    logic                    rsp_in;
    logic                    capture;

    fetch_next_pc #(
        .ADDRESS_BITS (ADDRESS_BITS)
    ) u_next_pc (
        .branch         (branch),
        .next_PC_select (next_PC_select),
        .branch_target  (branch_target),
        .JAL_target     (JAL_target),
        .JALR_target    (JALR_target),
        .redirect       (redirect),
        .target         (redirect_target)
    );

    // started keeps the request low while reset is held and for the release cycle
    assign imem_req_valid = started && (state == ST_REQ);
    assign imem_req_addr  = pc;
    assign accept         = imem_req_valid && imem_req_ready;
    assign rsp_in         = (state == ST_WAIT) && imem_rsp_valid;
    assign capture        = rsp_in && !drop && !redirect;

    // PC and FSM; redirect wins over everything, a request still in flight
    // (or accepted this very cycle) is waited out with drop set
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc      <= RESET_PC;
            state   <= ST_REQ;
            started <= 1'b0;
            drop    <= 1'b0;
        end else begin
            started <= 1'b1;
            if (redirect) begin
                pc <= redirect_target;
                if (((state == ST_WAIT) && !imem_rsp_valid) || accept) begin
                    state <= ST_WAIT;
                    drop  <= 1'b1;
                end else begin
                    state <= ST_REQ;
                    drop  <= 1'b0;
                end
            end else begin
                case (state)
                    ST_REQ: begin
                        if (accept) state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (imem_rsp_valid) begin
                            drop <= 1'b0;
                            if (!drop) begin
                                pc    <= pc + ADDRESS_BITS'(PC_INCREMENT);
                                state <= stall ? ST_HOLD : ST_REQ;
                            end else begin
                                state <= ST_REQ;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (!stall) state <= ST_REQ;
                    end
                    default: state <= ST_REQ;
                endcase
            end
        end
    end

    // IF/ID output register and 1-entry skid for a response caught under stall
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instruction <= '0;
            inst_PC     <= '0;
            inst_valid  <= 1'b0;
            skid_valid  <= 1'b0;
            skid_data   <= '0;
            skid_pc     <= '0;
        end else if (redirect) begin
            inst_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (stall) begin
            if (capture) begin
                if (!inst_valid) begin
                    instruction <= imem_rsp_data;
                    inst_PC     <= pc;
                    inst_valid  <= 1'b1;
                end else begin
                    skid_valid <= 1'b1;
                    skid_data  <= imem_rsp_data;
                    skid_pc    <= pc;
                end
            end
        end else begin
            if (capture) begin
                instruction <= imem_rsp_data;
                inst_PC     <= pc;
                inst_valid  <= 1'b1;
            end else if (skid_valid) begin
                instruction <= skid_data;
                inst_PC     <= skid_pc;
                inst_valid  <= 1'b1;
                skid_valid  <= 1'b0;
            end else begin
                inst_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_COUNTERS_EN
    logic        discard;
    logic [31:0] fetch_cnt;
    logic [31:0] squash_cnt;

    assign discard = rsp_in && (drop || redirect);

    // Count captured and squashed responses; both wrap naturally
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_cnt  <= '0;
            squash_cnt <= '0;
        end else begin
            if (capture) fetch_cnt  <= fetch_cnt + 32'd1;
            if (discard) squash_cnt <= squash_cnt + 32'd1;
        end
    end

    assign fetch_count  = fetch_cnt;
    assign squash_count = squash_cnt;
`else
    assign fetch_count  = '0;
    assign squash_count = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed table, corner sequences and random stimulus for
// fetch_unit, checked against a transaction-level program-order model.
module tb_fetch_unit;

    localparam logic [19:0] RST_PC = 20'h00100;

    logic        clock;
    logic        reset;
    logic        branch;
    logic [19:0] branch_target;
    logic [19:0] JAL_target;
    logic [19:0] JALR_target;
    logic [1:0]  next_PC_select;
    logic        stall;
    logic        imem_req_valid;
    logic [19:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] instruction;
    logic [19:0] inst_PC;
    logic        inst_valid;
    logic [31:0] fetch_count;
    logic [31:0] squash_count;

    fetch_unit #(
        .CORE         (0),
        .DATA_WIDTH   (32),
        .ADDRESS_BITS (20),
        .RESET_PC     (RST_PC)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .branch         (branch),
        .branch_target  (branch_target),
        .JAL_target     (JAL_target),
        .JALR_target    (JALR_target),
        .next_PC_select (next_PC_select),
        .stall          (stall),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instruction    (instruction),
        .inst_PC        (inst_PC),
        .inst_valid     (inst_valid),
        .fetch_count    (fetch_count),
        .squash_count   (squash_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Memory model and program-order model state
    bit          pending;
    int          pend_wait;
    logic [19:0] pend_addr;
    bit          mem_ready_en;
    int          lat_min;
    int          lat_max;
    int          rsp_total;
    bit          prev_hold;
    logic [19:0] prev_addr;
    logic [19:0] exp_pc;
    logic [19:0] req_log[$];
    logic [19:0] cons_log[$];

    typedef struct {
        logic [1:0]  sel;
        logic        br;
        logic [19:0] bt;
        logic [19:0] jt;
        logic [19:0] jrt;
        bit          redir;
        logic [19:0] exp_addr;
    } vec_t;
    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [19:0] a);
        return {a, 12'h5A3} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] req_at(input int i);
        return (i < req_log.size()) ? {12'h0, req_log[i]} : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] cons_at(input int i);
        return (i < cons_log.size()) ? {12'h0, cons_log[i]} : 32'hDEAD_BEEF;
    endfunction

    // One cycle: evaluate memory and consumer at mid-cycle, then advance
    task automatic tick();
        bit          redir;
        logic [19:0] tgt;
        if (reset) begin
            if (prev_hold) begin
                check("req_hold_valid", {31'b0, imem_req_valid}, 32'd1);
                check("req_hold_addr", {12'h0, imem_req_addr}, {12'h0, prev_addr});
            end
            imem_rsp_valid = 1'b0;
            if (pending) begin
                if (pend_wait == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(pend_addr);
                    pending        = 1'b0;
                    rsp_total++;
                end else begin
                    pend_wait--;
                end
            end
            imem_req_ready = mem_ready_en;
            if (imem_req_valid)
                check("one_outstanding", {31'b0, pending | imem_rsp_valid}, 32'd0);
            if (imem_req_valid && imem_req_ready) begin
                pending   = 1'b1;
                pend_addr = imem_req_addr;
                pend_wait = $urandom_range(lat_max, lat_min) - 1;
                req_log.push_back(imem_req_addr);
            end
            if (inst_valid && !stall) begin
                check("cons_pc", {12'h0, inst_PC}, {12'h0, exp_pc});
                check("cons_data", instruction, mem_word(inst_PC));
                cons_log.push_back(inst_PC);
                exp_pc = exp_pc + 20'd4;
            end
            redir = (next_PC_select == 2'b01 && branch) || next_PC_select[1];
            case (next_PC_select)
                2'b10:   tgt = JAL_target;
                2'b11:   tgt = JALR_target;
                default: tgt = branch_target;
            endcase
            if (redir) exp_pc = {tgt[19:2], 2'b00};
            prev_hold = imem_req_valid && !imem_req_ready && !redir;
            prev_addr = imem_req_addr;
        end else begin
            pending        = 1'b0;
            imem_rsp_valid = 1'b0;
            imem_req_ready = 1'b0;
            prev_hold      = 1'b0;
            rsp_total      = 0;
            exp_pc         = RST_PC;
        end
        @(negedge clock);
    endtask

    task automatic wait_req(input string name);
        for (int i = 0; i < 40 && !imem_req_valid; i++) tick();
        check(name, {31'b0, imem_req_valid}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'd0);
        check({tag, "_req_addr"}, {12'h0, imem_req_addr}, {12'h0, RST_PC});
        check({tag, "_instruction"}, instruction, 32'd0);
        check({tag, "_inst_pc"}, {12'h0, inst_PC}, 32'd0);
        check({tag, "_inst_valid"}, {31'b0, inst_valid}, 32'd0);
        check({tag, "_fetch_count"}, fetch_count, 32'd0);
        check({tag, "_squash_count"}, squash_count, 32'd0);
    endtask

    initial begin
        logic [31:0] snap_instr;
        logic [19:0] snap_pc;
        logic        snap_valid;
        logic [19:0] p;
        logic [19:0] exp_next;
        logic [31:0] sq_before;
        logic [31:0] exp_sq;
        int          n0;
        int          c0;

        reset = 1'b0; stall = 1'b0; branch = 1'b0; next_PC_select = 2'b00;
        branch_target = '0; JAL_target = '0; JALR_target = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        pending = 1'b0; pend_wait = 0; pend_addr = '0; rsp_total = 0;
        prev_hold = 1'b0; prev_addr = '0; exp_pc = RST_PC;
        mem_ready_en = 1'b1; lat_min = 1; lat_max = 1;

        vecs[0] = '{2'b00, 1'b0, 20'h00040, 20'h00AAC, 20'h00BBC, 1'b0, 20'h00000};
        vecs[1] = '{2'b01, 1'b0, 20'h00040, 20'h00AAC, 20'h00BBC, 1'b0, 20'h00000};
        vecs[2] = '{2'b01, 1'b1, 20'h00040, 20'h00AAC, 20'h00BBC, 1'b1, 20'h00040};
        vecs[3] = '{2'b10, 1'b0, 20'h00044, 20'h00203, 20'h00BBC, 1'b1, 20'h00200};
        vecs[4] = '{2'b11, 1'b1, 20'h00044, 20'h00300, 20'h0ABCF, 1'b1, 20'h0ABCC};
        vecs[5] = '{2'b00, 1'b1, 20'h00300, 20'h00400, 20'h00500, 1'b0, 20'h00000};
        vecs[6] = '{2'b01, 1'b1, 20'h12347, 20'h00400, 20'h00500, 1'b1, 20'h12344};
        vecs[7] = '{2'b10, 1'b1, 20'h00500, 20'h00601, 20'h00700, 1'b1, 20'h00600};
        vecs[8] = '{2'b11, 1'b0, 20'h00500, 20'h00600, 20'hFFFFE, 1'b1, 20'hFFFFC};

        // Reset state and first request
        @(negedge clock);
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b1;
        tick();
        check("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("first_req_addr", {12'h0, imem_req_addr}, {12'h0, RST_PC});

        // Sequential stream up to 0x00104 on the output
        for (int i = 0; i < 30 && !(inst_valid && inst_PC == 20'h00104); i++) tick();
        check("reach_104_valid", {31'b0, inst_valid}, 32'd1);
        check("reach_104_pc", {12'h0, inst_PC}, 32'h00104);
        check("req0", req_at(0), 32'h00100);
        check("req1", req_at(1), 32'h00104);
        check("cons0", cons_at(0), 32'h00100);

        // Stall for 5 cycles: outputs frozen, at most one more request
        snap_instr = instruction; snap_pc = inst_PC; snap_valid = inst_valid;
        n0 = req_log.size();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_instr", instruction, snap_instr);
            check("stall_pc", {12'h0, inst_PC}, {12'h0, snap_pc});
            check("stall_valid", {31'b0, inst_valid}, {31'b0, snap_valid});
        end
        check("stall_req_count", {31'b0, (req_log.size() - n0) <= 1}, 32'd1);
        stall = 1'b0;
        c0 = cons_log.size();
        for (int i = 0; i < 20 && cons_log.size() < c0 + 2; i++) tick();
        check("post_stall_cons0", cons_at(c0), 32'h00104);
        check("post_stall_cons1", cons_at(c0 + 1), 32'h00108);
        check("req2", req_at(2), 32'h00108);

        // JAL while waiting on memory: response squashed, restart at 0x00200
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 40 && !(pending && pend_wait >= 1); i++) tick();
        check("jal_in_wait", {31'b0, pending}, 32'd1);
        sq_before = squash_count;
        next_PC_select = 2'b10; JAL_target = 20'h00203;
        tick();
        next_PC_select = 2'b00;
        check("jal_bubble", {31'b0, inst_valid}, 32'd0);
        wait_req("jal_wait_req");
        check("jal_req_addr", {12'h0, imem_req_addr}, 32'h00200);
`ifdef FETCH_PERF_COUNTERS_EN
        exp_sq = sq_before + 32'd1;
`else
        exp_sq = 32'd0;
`endif
        check("jal_squash_count", squash_count, exp_sq);

        // Table of select/branch/target vectors
        lat_min = 1; lat_max = 1;
        foreach (vecs[k]) begin
            wait_req("vec_wait_req_a");
            p = imem_req_addr;
            next_PC_select = vecs[k].sel; branch = vecs[k].br;
            branch_target = vecs[k].bt; JAL_target = vecs[k].jt; JALR_target = vecs[k].jrt;
            tick();
            next_PC_select = 2'b00; branch = 1'b0;
            tick();
            wait_req("vec_wait_req_b");
            exp_next = vecs[k].redir ? vecs[k].exp_addr : p + 20'd4;
            check($sformatf("vec%0d_next_req", k), {12'h0, imem_req_addr}, {12'h0, exp_next});
        end

        // Wrap: 0xFFFFC is followed by 0x00000
        tick();
        tick();
        wait_req("wrap_wait_req");
        check("wrap_req_addr", {12'h0, imem_req_addr}, 32'h00000);

        // Memory not ready for 3 cycles, then async reset mid-WAIT
        mem_ready_en = 1'b0;
        wait_req("nrdy_wait_req");
        p = imem_req_addr;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("nrdy_valid", {31'b0, imem_req_valid}, 32'd1);
            check("nrdy_addr", {12'h0, imem_req_addr}, {12'h0, p});
        end
        mem_ready_en = 1'b1; lat_min = 4; lat_max = 4;
        tick();
        tick();
        check("mid_wait_pending", {31'b0, pending}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        pending = 1'b0; imem_rsp_valid = 1'b0;
        @(negedge clock);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        check("restart_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("restart_req_addr", {12'h0, imem_req_addr}, {12'h0, RST_PC});

        // Random traffic against the program-order model
        lat_min = 1; lat_max = 3;
        c0 = cons_log.size();
        for (int i = 0; i < 3000; i++) begin
            stall        = ($urandom_range(99, 0) < 30);
            mem_ready_en = ($urandom_range(99, 0) < 75);
            branch_target = 20'($urandom);
            JAL_target    = 20'($urandom);
            JALR_target   = 20'($urandom);
            if ($urandom_range(99, 0) < 6) begin
                next_PC_select = 2'($urandom_range(3, 1));
                branch         = 1'($urandom_range(1, 0));
            end else if ($urandom_range(1, 0) == 1) begin
                next_PC_select = 2'b01; branch = 1'b0;
            end else begin
                next_PC_select = 2'b00; branch = 1'($urandom_range(1, 0));
            end
            tick();
        end
        check("rand_progress", {31'b0, (cons_log.size() - c0) > 100}, 32'd1);

        // Drain and reconcile counters with responses returned
        stall = 1'b0; next_PC_select = 2'b00; branch = 1'b0; mem_ready_en = 1'b0;
        for (int i = 0; i < 20 && pending; i++) tick();
        check("drain_done", {31'b0, pending}, 32'd0);
`ifdef FETCH_PERF_COUNTERS_EN
        check("count_sum", fetch_count + squash_count, rsp_total);
`else
        check("fetch_count_tied", fetch_count, 32'd0);
        check("squash_count_tied", squash_count, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
